// File: rtl/regfile_access_ctrl.sv
// Command/response front end for a 1-write/1-read register file with a combinational read path.
// It serialises single writes, single reads and whole-file dumps onto the regfile port set.
module regfile_access_ctrl #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic                  cmd_dump,
   input  logic [ADDR_WIDTH-1:0] cmd_address,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ADDR_WIDTH-1:0] rsp_address,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_last,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] rf_write_address,
   output logic [DATA_WIDTH-1:0] rf_write_data,
   output logic                  rf_write_enable,
   output logic [ADDR_WIDTH-1:0] rf_read_address,
   input  logic [DATA_WIDTH-1:0] rf_read_data
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, DREAD, DRESP} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;

   assign busy = (state != IDLE);

   // A transfer happens on a rising clk edge where valid and ready are both high;
   // rsp_* are held unchanged while rsp_valid is high and rsp_ready is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         ptr              <= '0;
         cmd_ready        <= 1'b0;
         rsp_valid        <= 1'b0;
         rsp_address      <= '0;
         rsp_data         <= '0;
         rsp_last         <= 1'b0;
         rf_write_address <= '0;
         rf_write_data    <= '0;
         rf_write_enable  <= 1'b0;
         rf_read_address  <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (cmd_dump) begin
                     ptr             <= '0;
                     rf_read_address <= '0;
                     state           <= DREAD;
                  end else if (cmd_write) begin
                     rf_write_enable  <= 1'b1;
                     rf_write_address <= cmd_address;
                     rf_write_data    <= cmd_data;
                     state            <= WRITE;
                  end else begin
                     rf_read_address <= cmd_address;
                     state           <= READ;
                  end
               end
            end
            WRITE: begin
               rf_write_enable <= 1'b0;
               cmd_ready       <= 1'b1;
               state           <= IDLE;
            end
            READ: begin
               rsp_data    <= rf_read_data;
               rsp_address <= rf_read_address;
               rsp_last    <= 1'b1;
               rsp_valid   <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            DREAD: begin
               rsp_data    <= rf_read_data;
               rsp_address <= rf_read_address;
               rsp_last    <= (ptr == LAST_ADDR);
               rsp_valid   <= 1'b1;
               state       <= DRESP;
            end
            DRESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  // ptr stops at the last register instead of wrapping
                  if (ptr == LAST_ADDR) begin
                     cmd_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     ptr             <= ptr + 1'b1;
                     rf_read_address <= ptr + 1'b1;
                     state           <= DREAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural regfile, reference register image and
// a response scoreboard fed from the command driver.
module tb_regfile_access_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic       cmd_dump = 1'b0;
   logic [1:0] cmd_address = '0;
   logic [7:0] cmd_data = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [1:0] rsp_address;
   logic [7:0] rsp_data;
   logic       rsp_last;
   logic       busy;
   logic [1:0] rf_write_address;
   logic [7:0] rf_write_data;
   logic       rf_write_enable;
   logic [1:0] rf_read_address;
   logic [7:0] rf_read_data;

   int          errors = 0;
   int          checks = 0;
   logic [10:0] exp_q[$];
   logic [7:0]  ref_mem[4];
   logic [7:0]  rf_mem[4];
   int          we_count = 0;
   logic [1:0]  we_addr = '0;
   logic [7:0]  we_data = '0;
   bit          rand_ready_en = 1'b0;

   regfile_access_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_dump(cmd_dump), .cmd_address(cmd_address), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_address(rsp_address),
      .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
      .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
      .rf_write_enable(rf_write_enable), .rf_read_address(rf_read_address),
      .rf_read_data(rf_read_data)
   );

   // clock / reset-free infrastructure: clock, regfile, stall generator
   always #5 clk = ~clk;

   always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_address] <= rf_write_data;
   assign rf_read_data = rf_mem[rf_read_address];

   always @(posedge clk) begin
      #1;
      if (rand_ready_en) rsp_ready = 1'($urandom_range(0, 1));
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every response handshake pops one expected {address, data, last}
   always @(negedge clk) begin
      if (rf_write_enable) begin
         we_count++;
         we_addr = rf_write_address;
         we_data = rf_write_data;
      end
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
         else check("rsp", {21'd0, rsp_address, rsp_data, rsp_last}, {21'd0, exp_q.pop_front()});
      end
   end

   // driver tasks: all start and end 1 time unit after a rising edge
   task automatic send_cmd(input logic w, input logic d, input logic [1:0] a, input logic [7:0] dd);
      bit ok = 1'b0;
      cmd_valid = 1'b1; cmd_write = w; cmd_dump = d; cmd_address = a; cmd_data = dd;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_dump = 1'b0;
      check("cmd_accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic do_write(input logic [1:0] a, input logic [7:0] dd);
      send_cmd(1'b1, 1'b0, a, dd);
      ref_mem[a] = dd;
   endtask

   task automatic do_read(input logic [1:0] a);
      exp_q.push_back({a, ref_mem[a], 1'b1});
      send_cmd(1'b0, 1'b0, a, 8'h00);
   endtask

   task automatic do_dump(input logic w);
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ia;
         ia = i[1:0];
         exp_q.push_back({ia, ref_mem[i], (i == 3) ? 1'b1 : 1'b0});
      end
      send_cmd(w, 1'b1, 2'd1, 8'hAA);
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         @(negedge clk);
         if (cmd_ready && exp_q.size() == 0) ok = 1'b1;
      end
      @(posedge clk); #1;
      check(tag, {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_rsp_valid(input string tag);
      bit ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (rsp_valid) ok = 1'b1;
      end
      check(tag, {31'd0, ok}, 32'd1);
   endtask

   task automatic release_reset(input string tag);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check({tag, "_rdy_before_edge"}, {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_rdy_after_edge"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset values
      #7;
      check("reset_ctrl", {28'd0, cmd_ready, rsp_valid, rsp_last, busy}, 32'd0);
      check("reset_rsp", {22'd0, rsp_address, rsp_data}, 32'd0);
      check("reset_rf", {12'd0, rf_write_address, rf_write_data, rf_write_enable, rf_read_address}, 32'd0);
      release_reset("reset_release");

      // write a=2 then read a=2, with latency checks
      rsp_ready = 1'b1;
      we_count = 0;
      do_write(2'd2, 8'h12);
      @(negedge clk);
      check("wr_pulse", {21'd0, rf_write_enable, rf_write_address, rf_write_data}, {21'd0, 1'b1, 2'd2, 8'h12});
      check("wr_busy_rdy", {30'd0, busy, cmd_ready}, 32'd2);
      @(negedge clk);
      check("wr_done", {30'd0, rf_write_enable, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      do_read(2'd2);
      @(negedge clk);
      check("rd_lat_early", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      check("rd_lat_valid", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
      check("rd_lat_ready_back", {30'd0, rsp_valid, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      check("wr_pulse_count", we_count, 32'd1);
      check("wr_pulse_target", {22'd0, we_addr, we_data}, {22'd0, 2'd2, 8'h12});

      // fill and dump
      for (int i = 0; i < 4; i++) do_write(i[1:0], 8'h10 + 8'(i));
      do_dump(1'b0);
      wait_idle("dump_drain");

      // reset in the middle of DRESP
      rsp_ready = 1'b0;
      do_dump(1'b0);
      wait_rsp_valid("dresp_reached");
      check("dresp_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_outputs", {29'd0, rsp_valid, rf_write_enable, cmd_ready}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      release_reset("abort_release");

      // reset in the middle of WRITE drops the write enable at once
      send_cmd(1'b1, 1'b0, 2'd3, 8'hEE);
      check("midwr_enable", {31'd0, rf_write_enable}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("midwr_abort", {31'd0, rf_write_enable}, 32'd0);
      release_reset("midwr_release");
      rsp_ready = 1'b1;
      do_read(2'd3);
      wait_idle("midwr_readback");

      // read with a held-off consumer
      rsp_ready = 1'b0;
      do_read(2'd1);
      wait_rsp_valid("stall_valid");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_hold", {20'd0, rsp_valid, cmd_ready, busy, rsp_address, rsp_data},
               {20'd0, 1'b1, 1'b0, 1'b1, 2'd1, ref_mem[1]});
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_idle("stall_release");

      // dump wins over write
      we_count = 0;
      do_dump(1'b1);
      wait_idle("dump_write_drain");
      check("dump_write_no_we", we_count, 32'd0);

      // random command and stall mix
      rand_ready_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int k;
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         k = $urandom_range(0, 19);
         if (k < 10) do_write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         else if (k < 17) do_read(2'($urandom_range(0, 3)));
         else do_dump(1'($urandom_range(0, 1)));
      end
      wait_idle("random_drain");
      rand_ready_en = 1'b0;
      rsp_ready = 1'b1;
      check("random_queue_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
